tt_um_ternary_mac: RTL and testbench



---
 rtl/tt_um_ternary_mac.sv | 152 +++++++++++++++
 tb/tb_tt_um_ternary_mac.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tt_um_ternary_mac.sv
// tt_um_ternary_mac: ternary matrix-vector multiply-accumulate engine.
// Streams one signed activation per accepted cycle and adds, subtracts or
// skips it into one accumulator per output neuron, selected by the 2-bit
// ternary weight (01 = +1, 11 = -1, 00/10 = 0). After a full input vector
// the MAX_OUT_LEN sums are drained serially, one per cycle.
// Optional build macro: TERNARY_MAC_RELU_EN clamps negative results to zero
// on the output only; the accumulators keep their raw values.
// Reset is synchronous, active-low. ena low behaves like reset (abort).
// Assumes MAX_OUT_LEN >= 2 so that uo_out_idx has at least one bit.

module tt_um_ternary_mac #(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8,
  parameter int IN_BITS     = 8,
  parameter int ACC_BITS    = 13
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 ena,
  input  logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0]  ui_weights,
  input  logic                                 ui_in_valid,
  input  logic [IN_BITS-1:0]                   ui_in_data,
  output logic                                 uo_out_valid,
  output logic [ACC_BITS-1:0]                  uo_out_data,
  output logic [$clog2(MAX_OUT_LEN)-1:0]       uo_out_idx,
  output logic                                 uo_busy,
  output logic                                 uo_done
);

  localparam int OIDX_W = $clog2(MAX_OUT_LEN);
  localparam int IIDX_W = (MAX_IN_LEN > 1) ? $clog2(MAX_IN_LEN) : 1;
  localparam logic [IIDX_W-1:0] LAST_IN  = IIDX_W'(MAX_IN_LEN - 1);
  localparam logic [OIDX_W-1:0] LAST_OUT = OIDX_W'(MAX_OUT_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Contribution of one activation under one ternary weight: add, subtract or skip.
  function automatic logic signed [ACC_BITS-1:0] ternary_term(
    input logic [1:0]                 w,
    input logic signed [ACC_BITS-1:0] x
  );
    logic signed [ACC_BITS-1:0] t;
    case (w)
      2'b01:   t = x;
      2'b11:   t = -x;
      default: t = {ACC_BITS{1'b0}};
    endcase
    return t;
  endfunction

  state_t                      r_state;
  logic [IIDX_W-1:0]           r_in_idx;
  logic [OIDX_W-1:0]           r_out_idx;
  logic signed [ACC_BITS-1:0]  r_acc      [MAX_OUT_LEN];

  logic [2*MAX_OUT_LEN-1:0]    w_rows     [MAX_IN_LEN];
  logic [2*MAX_OUT_LEN-1:0]    w_row;
  logic signed [ACC_BITS-1:0]  w_x_ext;
  logic signed [ACC_BITS-1:0]  w_acc_next [MAX_OUT_LEN];
  logic signed [ACC_BITS-1:0]  w_sel_acc;

  // Split the flat weight bus into one row (all outputs) per input index.
  for (genvar gi = 0; gi < MAX_IN_LEN; gi++) begin : g_rows
    assign w_rows[gi] = ui_weights[gi*2*MAX_OUT_LEN +: 2*MAX_OUT_LEN];
  end

  // Row for the current input, sign-extended activation and updated sums.
  always_comb begin
    w_row   = w_rows[r_in_idx];
    w_x_ext = {{(ACC_BITS-IN_BITS){ui_in_data[IN_BITS-1]}}, ui_in_data};
    for (int j = 0; j < MAX_OUT_LEN; j++) begin
      w_acc_next[j] = r_acc[j] + ternary_term(w_row[2*j +: 2], w_x_ext);
    end
  end

  // Control FSM and accumulators; reset and ena-low abort clear everything.
  always_ff @(posedge clk) begin
    if (!rst_n || !ena) begin
      r_state   <= S_IDLE;
      r_in_idx  <= {IIDX_W{1'b0}};
      r_out_idx <= {OIDX_W{1'b0}};
      for (int j = 0; j < MAX_OUT_LEN; j++) begin
        r_acc[j] <= {ACC_BITS{1'b0}};
      end
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (ui_in_valid) begin
            for (int j = 0; j < MAX_OUT_LEN; j++) begin
              r_acc[j] <= w_acc_next[j];
            end
            if (r_in_idx == LAST_IN) begin
              r_in_idx <= {IIDX_W{1'b0}};
              r_state  <= S_DRAIN;
            end else begin
              r_in_idx <= r_in_idx + IIDX_W'(1);
              r_state  <= S_ACCUM;
            end
          end else begin
            r_state <= r_state;
          end
        end
        S_DRAIN: begin
          if (r_out_idx == LAST_OUT) begin
            r_out_idx <= {OIDX_W{1'b0}};
            r_state   <= S_IDLE;
            for (int j = 0; j < MAX_OUT_LEN; j++) begin
              r_acc[j] <= {ACC_BITS{1'b0}};
            end
          end else begin
            r_out_idx <= r_out_idx + OIDX_W'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_in_idx  <= {IIDX_W{1'b0}};
          r_out_idx <= {OIDX_W{1'b0}};
        end
      endcase
    end
  end

  // Result interface decoded from state and the drain index; zero outside DRAIN.
  always_comb begin
    w_sel_acc = r_acc[r_out_idx];
    uo_busy   = (r_state != S_IDLE);
    if (r_state == S_DRAIN) begin
      uo_out_valid = 1'b1;
      uo_out_idx   = r_out_idx;
      uo_done      = (r_out_idx == LAST_OUT);
`ifdef TERNARY_MAC_RELU_EN
      if (w_sel_acc[ACC_BITS-1]) begin
        uo_out_data = {ACC_BITS{1'b0}};
      end else begin
        uo_out_data = w_sel_acc;
      end
`else
      uo_out_data = w_sel_acc;
`endif
    end else begin
      uo_out_valid = 1'b0;
      uo_out_idx   = {OIDX_W{1'b0}};
      uo_done      = 1'b0;
      uo_out_data  = {ACC_BITS{1'b0}};
    end
  end

endmodule

// File: tb/tb_tt_um_ternary_mac.sv
// Self-checking bench for tt_um_ternary_mac: directed scenarios plus
// randomized vectors, all compared against sums computed directly from the
// ternary weight rules with plain integer arithmetic.

module tb_tt_um_ternary_mac;

  localparam int NI = 16;
  localparam int NO = 8;
  localparam int IB = 8;
  localparam int AB = 13;

  logic                  clk;
  logic                  rst_n;
  logic                  ena;
  logic [2*NI*NO-1:0]    wts;
  logic                  ui_in_valid;
  logic [IB-1:0]         ui_in_data;
  logic                  uo_out_valid;
  logic [AB-1:0]         uo_out_data;
  logic [2:0]            uo_out_idx;
  logic                  uo_busy;
  logic                  uo_done;

  int n_total;
  int n_bad;
  int xv [NI];

  tt_um_ternary_mac dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .ui_weights   (wts),
    .ui_in_valid  (ui_in_valid),
    .ui_in_data   (ui_in_data),
    .uo_out_valid (uo_out_valid),
    .uo_out_data  (uo_out_data),
    .uo_out_idx   (uo_out_idx),
    .uo_busy      (uo_busy),
    .uo_done      (uo_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int wval(input int i, input int j);
    logic [1:0] b;
    b = wts[i*2*NO + 2*j +: 2];
    if (b == 2'b01) return 1;
    else if (b == 2'b11) return -1;
    else return 0;
  endfunction

  function automatic void set_w(input int i, input int j, input logic [1:0] b);
    wts[i*2*NO + 2*j +: 2] = b;
  endfunction

  // Expected drained value for output j given current weights and xv[].
  function automatic int expect_out(input int j);
    int s;
    s = 0;
    for (int i = 0; i < NI; i++) s += wval(i, j) * xv[i];
`ifdef TERNARY_MAC_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  // Feed xv[] (optionally with idle gaps / activations during drain) and
  // check the drained results. Entered and left at a negedge.
  task automatic run_vector(input bit gaps, input bit noise);
    int exp [NO];
    for (int j = 0; j < NO; j++) exp[j] = expect_out(j);
    for (int i = 0; i < NI; i++) begin
      ui_in_valid = 1'b1;
      ui_in_data  = IB'(xv[i]);
      @(posedge clk); @(negedge clk);
      if (i < NI-1) begin
        check_eq("busy_accum", int'(uo_busy), 1);
        check_eq("no_early_valid", int'(uo_out_valid), 0);
        if (gaps) begin
          ui_in_valid = 1'b0;
          ui_in_data  = IB'($urandom);
          @(posedge clk); @(negedge clk);
          check_eq("busy_stall", int'(uo_busy), 1);
          check_eq("stall_valid", int'(uo_out_valid), 0);
        end
      end
    end
    for (int k = 0; k < NO; k++) begin
      check_eq("out_valid", int'(uo_out_valid), 1);
      check_eq("out_idx", int'(uo_out_idx), k);
      check_eq("out_data", int'($signed(uo_out_data)), exp[k]);
      check_eq("out_done", int'(uo_done), (k == NO-1) ? 1 : 0);
      check_eq("out_busy", int'(uo_busy), 1);
      ui_in_valid = noise && (k != NO-1);
      ui_in_data  = IB'($urandom);
      @(posedge clk); @(negedge clk);
    end
    check_eq("post_valid", int'(uo_out_valid), 0);
    check_eq("post_busy", int'(uo_busy), 0);
    check_eq("post_done", int'(uo_done), 0);
  endtask

  initial begin
    n_total = 0;
    n_bad = 0;
    rst_n = 1'b0;
    ena = 1'b1;
    wts = '0;
    ui_in_valid = 1'b0;
    ui_in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", int'(uo_out_valid), 0);
    check_eq("rst_data", int'(uo_out_data), 0);
    check_eq("rst_idx", int'(uo_out_idx), 0);
    check_eq("rst_busy", int'(uo_busy), 0);
    check_eq("rst_done", int'(uo_done), 0);
    rst_n = 1'b1;

    // All +1, x = 1..16 -> 136 everywhere.
    for (int i = 0; i < NI; i++) begin
      xv[i] = i + 1;
      for (int j = 0; j < NO; j++) set_w(i, j, 2'b01);
    end
    run_vector(1'b0, 1'b0);

    // All -1, x = -128 -> +2048, no wrap.
    for (int i = 0; i < NI; i++) begin
      xv[i] = -128;
      for (int j = 0; j < NO; j++) set_w(i, j, 2'b11);
    end
    run_vector(1'b0, 1'b0);

    // Diagonal +1 / -1 with 00 and 10 fillers, x = i -> -8 (0 with ReLU).
    for (int i = 0; i < NI; i++) begin
      xv[i] = i;
      for (int j = 0; j < NO; j++) begin
        if (i == j) set_w(i, j, 2'b01);
        else if (i == j + NO) set_w(i, j, 2'b11);
        else set_w(i, j, ((i + j) % 2 == 0) ? 2'b00 : 2'b10);
      end
    end
    run_vector(1'b0, 1'b0);

    // First scenario again with a gap every other cycle (31 input cycles).
    for (int i = 0; i < NI; i++) begin
      xv[i] = i + 1;
      for (int j = 0; j < NO; j++) set_w(i, j, 2'b01);
    end
    run_vector(1'b1, 1'b0);

    // Abort after 5 accepts, then a clean vector of ones -> 16.
    for (int i = 0; i < 5; i++) begin
      ui_in_valid = 1'b1;
      ui_in_data  = IB'($urandom_range(1, 100));
      @(posedge clk); @(negedge clk);
    end
    ena = 1'b0;
    ui_in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("abort_busy", int'(uo_busy), 0);
    check_eq("abort_valid", int'(uo_out_valid), 0);
    ena = 1'b1;
    for (int i = 0; i < NI; i++) xv[i] = 1;
    run_vector(1'b0, 1'b1);
    // Activations driven during the drain above must not leak into this one.
    run_vector(1'b0, 1'b0);

    // Randomized weights, activations and gaps.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NI; i++) begin
        xv[i] = int'($urandom_range(0, 255)) - 128;
        for (int j = 0; j < NO; j++) set_w(i, j, 2'($urandom));
      end
      run_vector(1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
